// File: rtl/frame_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_link_ctrl
// Brief    : Receive link controller: qualifies the link from block-sync and
//            per-packet checks, counts bad packets, requests block resync.
// Revision : 1.0 - initial release
// ============================================================================
module frame_link_ctrl #(
  parameter int GOOD_PKTS    = 8,
  parameter int BAD_PKTS     = 4,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int ERR_W        = 16
) (
  input  logic             clk_390p625M,
  input  logic             rst,
  input  logic             block_sync_rdy,
  input  logic             packet_wrong,
  input  logic             pkt_end,
  input  logic             clr_err,
  output logic             frame_en,
  output logic             link_up,
  output logic             resync_req,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       link_state
);

  localparam logic [1:0]       c_ST_HUNT   = 2'd0;
  localparam logic [1:0]       c_ST_CHECK  = 2'd1;
  localparam logic [1:0]       c_ST_LINKED = 2'd2;
  localparam logic [7:0]       c_GOOD_LAST = 8'(GOOD_PKTS - 1);
  localparam logic [7:0]       c_BAD_LAST  = 8'(BAD_PKTS - 1);
  localparam logic [15:0]      c_TMO_LAST  = 16'(SYNC_TIMEOUT - 1);
  localparam logic [ERR_W-1:0] c_ERR_MAX   = {ERR_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_frame_en;
  logic             r_link_up;
  logic             r_resync;
  logic [ERR_W-1:0] r_err_count;
  logic [7:0]       r_good_cnt;
  logic [7:0]       r_bad_cnt;
  logic [15:0]      r_tmo_cnt;
  logic             r_bad_seen;

  logic w_eval;
  logic w_bad;
  logic w_good;
  logic w_tmo_hit;
  logic w_good_done;
  logic w_bad_done;
  logic w_frame_en_nxt;
  logic w_link_up_nxt;
  logic w_resync_nxt;

  // A packet is judged on its pkt_end cycle, folding in any earlier error
  assign w_eval      = pkt_end & r_frame_en;
  assign w_bad       = w_eval & (r_bad_seen | packet_wrong);
  assign w_good      = w_eval & ~w_bad;
  assign w_tmo_hit   = ~block_sync_rdy & (r_tmo_cnt == c_TMO_LAST);
  assign w_good_done = w_good & (r_good_cnt == c_GOOD_LAST);
  assign w_bad_done  = w_bad & (r_bad_cnt == c_BAD_LAST);

  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sync loss outranks any packet verdict in CHECK/LINKED
  always_comb begin
    w_state_nxt = c_ST_HUNT;
    case (r_state)
      c_ST_HUNT:   w_state_nxt = block_sync_rdy ? c_ST_CHECK : c_ST_HUNT;
      c_ST_CHECK: begin
        if (!block_sync_rdy)  w_state_nxt = c_ST_HUNT;
        else if (w_good_done) w_state_nxt = c_ST_LINKED;
        else                  w_state_nxt = c_ST_CHECK;
      end
      c_ST_LINKED: begin
        if (!block_sync_rdy || w_bad_done) w_state_nxt = c_ST_HUNT;
        else                               w_state_nxt = c_ST_LINKED;
      end
      default:     w_state_nxt = c_ST_HUNT;
    endcase
  end

  always_comb begin
    w_frame_en_nxt = (w_state_nxt == c_ST_CHECK) || (w_state_nxt == c_ST_LINKED);
    w_link_up_nxt  = (w_state_nxt == c_ST_LINKED);
    w_resync_nxt   = 1'b0;
    case (r_state)
      c_ST_HUNT:   w_resync_nxt = w_tmo_hit;
      c_ST_LINKED: w_resync_nxt = block_sync_rdy & w_bad_done;
      default:     w_resync_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      r_frame_en <= 1'b0;
      r_link_up  <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      r_frame_en <= w_frame_en_nxt;
      r_link_up  <= w_link_up_nxt;
      r_resync   <= w_resync_nxt;
    end
  end

  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_bad_seen  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (r_state == c_ST_HUNT && !block_sync_rdy) begin
        r_tmo_cnt <= w_tmo_hit ? '0 : r_tmo_cnt + 16'd1;
      end else begin
        r_tmo_cnt <= '0;
      end

      if (r_state != c_ST_CHECK || w_bad) begin
        r_good_cnt <= '0;
      end else if (w_good) begin
        r_good_cnt <= r_good_cnt + 8'd1;
      end

      // Held at zero outside LINKED, so it is fresh on entry
      if (r_state != c_ST_LINKED || w_good) begin
        r_bad_cnt <= '0;
      end else if (w_bad) begin
        r_bad_cnt <= r_bad_cnt + 8'd1;
      end

      if (!r_frame_en || w_eval) begin
        r_bad_seen <= 1'b0;
      end else if (packet_wrong) begin
        r_bad_seen <= 1'b1;
      end

      if (clr_err) begin
        r_err_count <= '0;
      end else if (w_bad && r_err_count != c_ERR_MAX) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign frame_en   = r_frame_en;
  assign link_up    = r_link_up;
  assign resync_req = r_resync;
  assign err_count  = r_err_count;
  assign link_state = r_state;

endmodule
`default_nettype wire
